// File: rtl/power_seq_if.sv
// power_seq_if: operand/result bundle between a controller and power_seq_unit.
//   start    - operation request (sampled by the unit only while idle)
//   base     - base operand, BASE_W bits
//   exponent - exponent operand, EXP_W bits
//   busy     - unit is not idle
//   done     - one-cycle completion pulse
//   result   - last completed result, OUT_W bits, held until the next completion
//   ovf      - overflow status of the last completed operation
// Modports: master (controller side), slave (compute unit side).
interface power_seq_if #(
    parameter int unsigned BASE_W = 8,
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned OUT_W  = 16
);
    logic              start;
    logic [BASE_W-1:0] base;
    logic [EXP_W-1:0]  exponent;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  result;
    logic              ovf;

    modport master (
        output start, base, exponent,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, base, exponent,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/power_seq_unit.sv
// power_seq_unit: sequential integer exponentiation, result = base^exponent by repeated
// multiplication, one multiply per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset; abandons any operation in flight
//   bus   - power_seq_if slave modport (start/base/exponent in, busy/done/result/ovf out)
// Build option: define POWER_SEQ_SAT_EN to saturate the result to all ones when the
// operation overflowed OUT_W bits; otherwise the result is the value modulo 2^OUT_W.
module power_seq_unit #(
    parameter int unsigned BASE_W = 8,
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned OUT_W  = 16
) (
    input logic         clk,
    input logic         reset,
    power_seq_if.slave  bus
);
    localparam int unsigned PROD_W = OUT_W + BASE_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [BASE_W-1:0] b_reg;
    logic [EXP_W-1:0]  n_reg;
    logic [OUT_W-1:0]  acc;
    logic              ovf_acc;
    logic [OUT_W-1:0]  result_reg;
    logic              ovf_reg;

    logic [PROD_W-1:0] prod;
    logic [OUT_W-1:0]  final_val;

    // Full-width product so bits shifted past OUT_W can flag overflow.
    assign prod = PROD_W'(acc) * PROD_W'(b_reg);

`ifdef POWER_SEQ_SAT_EN
    assign final_val = ovf_acc ? {OUT_W{1'b1}} : acc;
`else
    assign final_val = acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            b_reg      <= '0;
            n_reg      <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_reg   <= bus.base;
                        n_reg   <= bus.exponent;
                        acc     <= OUT_W'(1);
                        ovf_acc <= 1'b0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (n_reg != '0) begin
                        acc     <= prod[OUT_W-1:0];
                        ovf_acc <= ovf_acc | (|prod[PROD_W-1:OUT_W]);
                        n_reg   <= n_reg - EXP_W'(1);
                    end else begin
                        result_reg <= final_val;
                        ovf_reg    <= ovf_acc;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input-to-output combinational path.
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_reg;
    assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_power_seq_unit.sv
// tb_power_seq_unit: directed plus randomized checks of power_seq_unit against an
// arithmetic reference model (exact power with clamping for overflow, modulo for value).
module tb_power_seq_unit;
    localparam int unsigned BASE_W = 8;
    localparam int unsigned EXP_W  = 4;
    localparam int unsigned OUT_W  = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    power_seq_if #(.BASE_W(BASE_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) bus ();

    power_seq_unit #(.BASE_W(BASE_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true power clamped at 2^OUT_W decides overflow; low bits by modulo.
    task automatic model(input int b, input int e, output int r, output bit o);
        longint lim;
        longint exact;
        longint m;
        lim   = longint'(1) << OUT_W;
        exact = 1;
        m     = 1;
        o     = 1'b0;
        for (int i = 0; i < e; i++) begin
            m     = (m * b) % lim;
            exact = exact * b;
            if (exact >= lim) begin
                o     = 1'b1;
                exact = lim;
            end
        end
        r = int'(m);
`ifdef POWER_SEQ_SAT_EN
        if (o) r = int'(lim - 1);
`endif
    endtask

    // Launch one operation from idle and check latency, result, ovf and hold behaviour.
    task automatic run_op(input int b, input int e, input string tag);
        int  er;
        bit  eo;
        int  n;
        model(b, e, er, eo);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = BASE_W'(b);
        bus.exponent = EXP_W'(e);
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.base     = BASE_W'($urandom);
        bus.exponent = EXP_W'($urandom);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(n), 32'(e + 1));
        check({tag, "_res"}, 32'(bus.result), 32'(er));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
        check({tag, "_donelow"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.result), 32'(er));
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dones;
        int er;
        bit eo;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", 32'(bus.result), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3, 5, "basic");
        run_op(0, 0, "zero_zero");
        run_op(0, 7, "zero_base");
        run_op(1, 15, "one_base");
        run_op(2, 15, "two_15");
        run_op(255, 2, "ff_sq");
        run_op(255, 3, "ovf");
        run_op(2, 4, "after_ovf");

        // Start held high with operands changing during MUL: one completion only.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = 8'd3;
        bus.exponent = 4'd4;
        @(posedge clk);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.base     = BASE_W'($urandom);
            bus.exponent = EXP_W'($urandom);
            if (bus.done) dones++;
            @(posedge clk);
        end
        @(negedge clk);
        if (bus.done) dones++;
        check("hs_done_seen", 32'(bus.done), 32'd1);
        check("hs_res", 32'(bus.result), 32'd81);
        bus.base     = 8'd2;
        bus.exponent = 4'd2;
        @(posedge clk);
        @(negedge clk);
        check("hs_idle_gap", 32'(bus.busy), 32'd0);
        check("hs_one_done", 32'(dones), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("hs_retrigger", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !bus.done; k++) begin
            @(negedge clk);
        end
        check("hs_second_res", 32'(bus.result), 32'd4);
        @(negedge clk);

        // Reset during MUL abandons the operation.
        bus.start    = 1'b1;
        bus.base     = 8'd7;
        bus.exponent = 4'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_res", 32'(bus.result), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("mid_rst_quiet", 32'(dones), 32'd0);
        run_op(2, 3, "post_rst");

        // Randomized operations against the model.
        for (int k = 0; k < 24; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), "rand");
        end
        model(255, 3, er, eo);
        check("model_ovf_flag", 32'(eo), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/power_seq_unit.md
Name: power_seq_unit

Overview:
- Parametrised sequential integer exponentiation unit: computes base^exponent by iterated multiplication.
- Generalises the fixed 3-bit power block in three ways:
  - configurable operand and result widths;
  - operands captured at start, with a start/busy/done handshake;
  - a registered, held result plus an overflow flag.
- Sits as a slave compute block driven by a control FSM or register interface, one operation in flight at a time.

Parameters:
- BASE_W, 8, base operand width in bits (>=1).
- EXP_W, 4, exponent operand width in bits (>=1); max exponent 2^EXP_W-1.
- OUT_W, 16, result width in bits (>=BASE_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- base  input  BASE_W  base operand, captured on the accepted start edge.
- exponent  input  EXP_W  exponent operand, captured on the accepted start edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  OUT_W  last completed result; held until the next completion.
- ovf  output  1  overflow status of the last completed operation; held with result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, ovf=0, internal acc/count/ovf_acc=0. Reset mid-operation abandons the operation; no done pulse.
- States: IDLE, MUL, DONE.
- IDLE:
  - start=1 at an edge: capture b_reg=base, n_reg=exponent; acc=1, ovf_acc=0; go to MUL.
  - start=0: stay in IDLE.
- MUL, n_reg!=0, each edge:
  - prod = acc*b_reg at full width OUT_W+BASE_W.
  - acc = prod[OUT_W-1:0].
  - ovf_acc |= (prod[OUT_W+BASE_W-1:OUT_W] != 0).
  - n_reg decrements by 1.
  - Stay in MUL.
- MUL, n_reg==0, next edge: result=final value (see Optional Feature), ovf=ovf_acc; go to DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency:
  - Edge 0 samples start. Edges 1..E perform the multiplies (E = captured exponent). Edge E+1 enters DONE.
  - done is high in the cycle between edges E+1 and E+2.
  - Next start is accepted at edge E+2 at the earliest.
- start in MUL or DONE: ignored; no queuing. Input changes after capture have no effect.
- Exponent 0: result=1 for any base, including 0^0=1; ovf=0; done after edge 1.
- Base 0 with E>0: result=0, ovf=0.
- Base 1: result=1 for any E, ovf=0.
- Without saturation, result = base^E mod 2^OUT_W exactly; modular truncation each step preserves the low bits.
- ovf is sticky within an operation and cleared only at the next accepted start or at reset.
- done and busy are registered/state-decoded; no combinational path from inputs to outputs.

Optional Feature:
- Macro: POWER_SEQ_SAT_EN.
- Defined: when ovf_acc is set at DONE entry, result = all ones (2^OUT_W-1); ovf still reports 1. Otherwise identical.
- Undefined: result = truncated modular value as above.
- Iteration count and latency are identical in both builds.

Test Plan (defaults BASE_W=8, EXP_W=4, OUT_W=16):
- Basic: base=3, exp=5, start pulse -> busy from the next cycle; done after edge 6; result=243 (0x00F3), ovf=0; result held after done drops.
- Exponent zero: base=0, exp=0 -> done after edge 1; result=1, ovf=0. Then base=0, exp=7 -> result=0, ovf=0.
- Boundary: base=2, exp=15 -> result=0x8000, ovf=0. base=255, exp=2 -> 0xFE01, ovf=0.
- Overflow: base=255, exp=3.
  - Macro undefined -> result=0x02FF, ovf=1.
  - Macro defined -> result=0xFFFF, ovf=1.
  - A following base=2, exp=4 run -> result=16, ovf=0.
- Handshake: start held high and operand changes during MUL of base=3, exp=4 -> exactly one done, result=81; held start re-triggers only at the IDLE edge after DONE.
- Reset mid-op: assert reset during MUL of base=7, exp=9 -> outputs immediately 0 (busy, done, result, ovf); no done pulse; a fresh base=2, exp=3 run -> result=8.
